spi_frame_pixel_unpacker: RTL and testbench
===========================================

// Module: spi_frame_pixel_unpacker
// PURPOSE
//   Parametrised SPI RX-FIFO frame reader feeding the CNN input stage. Polls the AXI Quad SPI
//   RX FIFO, issues single-word reads, unpacks PIX_PER_WORD pixels per 32-bit word and streams
//   them out with valid/ready backpressure, (x,y) coordinates and frame markers. Adds timeout
//   detection, abort, and partial-word handling at frame end.
// PARAMETERS
//   FRAME_W       32      pixels per line
//   FRAME_H       32      lines per frame
//   PIX_W         8       bits per pixel
//   PIX_PER_WORD  4       pixels packed per RX word, LSB lane first; PIX_W*PIX_PER_WORD <= 32
//   RD_LATENCY    2       cycles from rd_valid to rd_data valid (>= 1)
//   MIN_OCC       1       RX occupancy required before issuing a read (>= 1)
//   TIMEOUT_CYC   65535   max cycles waiting in WAIT_OCC before error
//   RX_FIFO_ADDR  32'h6C  SPI RX FIFO register address
// PORTS
//   clk           in   1      clock
//   rst_n         in   1      async reset, active low
//   start         in   1      level; rising edge starts a frame
//   abort         in   1      synchronous abort, any state
//   rd_addr       out  32     SPI register address
//   rd_valid      out  1      one-cycle read request
//   rd_data       in   32     SPI read data
//   rx_occupancy  in   11     RX FIFO fill level
//   pix_valid     out  1      pixel valid
//   pix_ready     in   1      downstream ready
//   pix_data      out  PIX_W  pixel value
//   pix_x         out  $clog2(FRAME_W)  column of pix_data
//   pix_y         out  $clog2(FRAME_H)  line of pix_data
//   pix_last      out  1      high with the final pixel of the frame
//   frame_start   out  1      1-cycle pulse on accepted start
//   frame_done    out  1      1-cycle pulse after last pixel handshake
//   busy          out  1      high in any state except IDLE
//   err_timeout   out  1      sticky timeout flag
// BEHAVIOUR
//   Reset (rst_n low, async): state IDLE; all outputs 0 incl. rd_addr; counters and word reg 0.
//   States: IDLE, WAIT_OCC, REQ, WAIT_RD, UNPACK, DONE, ERROR.
//   IDLE: start rising edge (start & !start_d1) -> frame_start=1 next cycle, x=y=lane=0,
//     timeout cnt=0, clear err_timeout, -> WAIT_OCC. Edges while busy are ignored.
//   WAIT_OCC: rx_occupancy >= MIN_OCC -> REQ, timeout cnt cleared; else cnt++;
//     cnt == TIMEOUT_CYC-1 with no data -> ERROR.
//   REQ: rd_valid=1, rd_addr=RX_FIFO_ADDR for exactly one cycle (cycle t) -> WAIT_RD.
//   WAIT_RD: rd_data sampled into word reg on cycle t+RD_LATENCY -> UNPACK; lane=0.
//   UNPACK: pix_valid=1 from cycle t+RD_LATENCY+1; pix_data=word[lane*PIX_W +: PIX_W];
//     pix_data/x/y/last held stable while pix_valid & !pix_ready.
//     On handshake: x++ ; x==FRAME_W-1 wraps to 0 and y++. lane++.
//     Last frame pixel handshaken -> DONE (unused lanes of that word discarded).
//     Else lane==PIX_PER_WORD-1 handshaken -> WAIT_OCC (pix_valid 0 next cycle).
//   pix_last=1 iff x==FRAME_W-1 and y==FRAME_H-1 while pix_valid.
//   DONE: frame_done=1 for one cycle -> IDLE. Exactly FRAME_W*FRAME_H pixels per frame.
//   ERROR: err_timeout=1 (sticky), busy=1, pix_valid=0; start rising edge -> IDLE
//     (next edge starts a frame); abort -> IDLE. err_timeout clears only on next accepted start.
//   abort: any state -> IDLE next cycle; pix_valid, rd_valid drop; no frame_done; in-flight
//     rd_data discarded; abort with start same cycle: abort wins, no frame_start.
//   Reset mid-frame: immediate return to reset values; no pulses emitted.
//   Throughput: max 1 word per (RD_LATENCY+2+PIX_PER_WORD) cycles with pix_ready held 1.
// TESTING
//   1 Defaults, occ=8, words 0x03020100.., ready=1 -> 1024 pixels 0x00..0xFF repeating,
//     pix_x/pix_y raster, pix_last on pixel 1023, one frame_done, 256 rd_valid pulses.
//   2 PIX_PER_WORD=3, FRAME_W=FRAME_H=4 -> 6 reads; last word lanes 1,2 dropped; 16 pixels.
//   3 Random pix_ready (50%) -> pix_data/x/y stable while stalled; no pixel lost or duplicated.
//   4 occ=0 after start, TIMEOUT_CYC=100 -> ERROR at cycle 100, err_timeout=1, busy=1, no rd_valid.
//   5 abort during WAIT_RD at pixel 500 -> busy=0 next cycle, no frame_done; new start -> pixel 0 at x=y=0.
//   6 RD_LATENCY=4: rd_data driven only on t+4 -> correct capture; start held high -> one frame only.

Source files
------------

// File: rtl/spi_frame_pixel_unpacker.sv
// Reads packed pixel words from the SPI RX FIFO one word at a time and streams the pixels out
// in raster order with valid/ready, coordinates, frame markers and a sticky occupancy timeout.
module spi_frame_pixel_unpacker #(
  parameter int          FRAME_W      = 32,
  parameter int          FRAME_H      = 32,
  parameter int          PIX_W        = 8,
  parameter int          PIX_PER_WORD = 4,
  parameter int          RD_LATENCY   = 2,
  parameter int          MIN_OCC      = 1,
  parameter int          TIMEOUT_CYC  = 65535,
  parameter logic [31:0] RX_FIFO_ADDR = 32'h6C,
  localparam int         XW           = (FRAME_W > 1) ? $clog2(FRAME_W) : 1,
  localparam int         YW           = (FRAME_H > 1) ? $clog2(FRAME_H) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [31:0]      rd_addr,
  output logic             rd_valid,
  input  logic [31:0]      rd_data,
  input  logic [10:0]      rx_occupancy,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [PIX_W-1:0] pix_data,
  output logic [XW-1:0]    pix_x,
  output logic [YW-1:0]    pix_y,
  output logic             pix_last,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy,
  output logic             err_timeout
);

  localparam int LNW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int LTW = $clog2(RD_LATENCY + 1);
  localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int WW  = PIX_W * PIX_PER_WORD;

  localparam logic [XW-1:0]  X_MAX    = XW'(FRAME_W - 1);
  localparam logic [YW-1:0]  Y_MAX    = YW'(FRAME_H - 1);
  localparam logic [LNW-1:0] LANE_MAX = LNW'(PIX_PER_WORD - 1);
  localparam logic [LTW-1:0] LAT_MAX  = LTW'(RD_LATENCY);
  localparam logic [TW-1:0]  TMO_MAX  = TW'(TIMEOUT_CYC - 1);
  localparam logic [10:0]    OCC_MIN  = 11'(MIN_OCC);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_OCC, S_REQ, S_WAIT_RD, S_UNPACK, S_DONE, S_ERROR
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic           r_start_d1;
  logic           r_frame_start;
  logic           r_err_timeout;
  logic [TW-1:0]  r_tmo_cnt;
  logic [LTW-1:0] r_lat_cnt;
  logic [31:0]    r_word;
  logic [LNW-1:0] r_lane;
  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;

  logic             w_start_edge;
  logic             w_occ_ok;
  logic             w_last_pix;
  logic [PIX_W-1:0] w_lane_pix [PIX_PER_WORD];

  assign w_start_edge = start & ~r_start_d1;
  assign w_occ_ok     = (rx_occupancy >= OCC_MIN);
  assign w_last_pix   = (r_x == X_MAX) && (r_y == Y_MAX);

  for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_lane
    assign w_lane_pix[gi] = r_word[gi*PIX_W +: PIX_W];
  end

  // Bits above the packed lanes carry nothing when the lanes do not fill the word.
  if (WW < 32) begin : g_hi_bits
    logic w_unused_hi;
    assign w_unused_hi = ^r_word[31:WW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (w_start_edge) w_next_state = S_WAIT_OCC;
        S_WAIT_OCC: begin
          if (w_occ_ok) w_next_state = S_REQ;
          else if (r_tmo_cnt == TMO_MAX) w_next_state = S_ERROR;
        end
        S_REQ:      w_next_state = S_WAIT_RD;
        S_WAIT_RD:  if (r_lat_cnt == LAT_MAX) w_next_state = S_UNPACK;
        S_UNPACK: begin
          // The final pixel of the frame ends it even if lanes of its word remain.
          if (pix_ready) begin
            if (w_last_pix) w_next_state = S_DONE;
            else if (r_lane == LANE_MAX) w_next_state = S_WAIT_OCC;
          end
        end
        S_DONE:     w_next_state = S_IDLE;
        S_ERROR:    if (w_start_edge) w_next_state = S_IDLE;
        default:    w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_valid   = 1'b0;
    rd_addr    = '0;
    pix_valid  = 1'b0;
    pix_data   = '0;
    pix_x      = '0;
    pix_y      = '0;
    pix_last   = 1'b0;
    frame_done = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_REQ: begin
        rd_valid = 1'b1;
        rd_addr  = RX_FIFO_ADDR;
      end
      S_UNPACK: begin
        pix_valid = 1'b1;
        pix_data  = w_lane_pix[r_lane];
        pix_x     = r_x;
        pix_y     = r_y;
        pix_last  = w_last_pix;
      end
      S_DONE:  frame_done = 1'b1;
      default: ;
    endcase
  end

  assign frame_start = r_frame_start;
  assign err_timeout = r_err_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_d1    <= 1'b0;
      r_frame_start <= 1'b0;
      r_err_timeout <= 1'b0;
      r_tmo_cnt     <= '0;
      r_lat_cnt     <= '0;
      r_word        <= '0;
      r_lane        <= '0;
      r_x           <= '0;
      r_y           <= '0;
    end else begin
      r_start_d1    <= start;
      r_frame_start <= 1'b0;
      if (!abort) begin
        case (r_state)
          S_IDLE: begin
            if (w_start_edge) begin
              r_frame_start <= 1'b1;
              r_err_timeout <= 1'b0;
              r_tmo_cnt     <= '0;
              r_lane        <= '0;
              r_x           <= '0;
              r_y           <= '0;
            end
          end
          S_WAIT_OCC: begin
            if (w_occ_ok) r_tmo_cnt <= '0;
            else if (r_tmo_cnt == TMO_MAX) r_err_timeout <= 1'b1;
            else r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
          S_REQ: r_lat_cnt <= LTW'(1);
          S_WAIT_RD: begin
            if (r_lat_cnt == LAT_MAX) begin
              r_word <= rd_data;
              r_lane <= '0;
            end else begin
              r_lat_cnt <= r_lat_cnt + 1'b1;
            end
          end
          S_UNPACK: begin
            if (pix_ready) begin
              r_lane <= r_lane + 1'b1;
              if (r_x == X_MAX) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
              end else begin
                r_x <= r_x + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_pixel_unpacker.sv
// Bench for spi_frame_pixel_unpacker: a 32x32 instance (short timeout) and a 4x4, 3-lane,
// latency-4 instance, both fed by read-latency responders and checked against pixel scoreboards.
module tb_spi_frame_pixel_unpacker;

  localparam int W1 = 32, H1 = 32, P1 = 4, L1 = 2, TO1 = 100;
  localparam int W2 = 4,  H2 = 4,  P2 = 3, L2 = 4;
  localparam logic [31:0] BAD = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start, abort, pix_ready;
  logic [31:0] rd_data;
  logic [10:0] rx_occ;
  logic [31:0] rd_addr;
  logic        rd_valid, pix_valid, pix_last, frame_start, frame_done, busy, err_timeout;
  logic [7:0]  pix_data;
  logic [4:0]  pix_x, pix_y;

  logic        b_start, b_abort, b_ready;
  logic [31:0] b_rd_data;
  logic [10:0] b_occ;
  logic [31:0] b_rd_addr;
  logic        b_rd_valid, b_pix_valid, b_pix_last, b_frame_start, b_frame_done, b_busy, b_err;
  logic [7:0]  b_pix_data;
  logic [1:0]  b_pix_x, b_pix_y;

  spi_frame_pixel_unpacker #(.TIMEOUT_CYC(TO1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .rx_occupancy(rx_occ),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy), .err_timeout(err_timeout)
  );

  spi_frame_pixel_unpacker #(.FRAME_W(W2), .FRAME_H(H2), .PIX_PER_WORD(P2), .RD_LATENCY(L2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
    .rd_addr(b_rd_addr), .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rx_occupancy(b_occ),
    .pix_valid(b_pix_valid), .pix_ready(b_ready), .pix_data(b_pix_data),
    .pix_x(b_pix_x), .pix_y(b_pix_y), .pix_last(b_pix_last),
    .frame_start(b_frame_start), .frame_done(b_frame_done), .busy(b_busy), .err_timeout(b_err)
  );

  typedef struct { logic [7:0] d; int x; int y; logic last; } pix_t;
  typedef struct { bit rnd; int occ; int exp_pix; int exp_reads; int exp_done; int exp_last; } run_t;

  pix_t q1[$];
  pix_t q2[$];
  run_t runs[4];

  int n_cmp = 0, n_fail = 0;
  int c1_pix = 0, c1_rd = 0, c1_done = 0, c1_fs = 0, c1_last = 0, n1_word = 0;
  int c2_pix = 0, c2_rd = 0, c2_done = 0, c2_last = 0, n2_word = 0;
  logic [7:0] hist1 = '0, hist2 = '0;
  bit   ready_rnd = 1'b0;
  bit   prev_stall = 1'b0;
  logic [18:0] prev_pix = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // One cycle: sample outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic tick();
    bit   disturbed;
    pix_t e;
    @(negedge clk);
    disturbed = abort || !rst_n;
    pix_ready = ready_rnd ? 1'($urandom_range(0, 1)) : 1'b1;

    if (prev_stall && !disturbed)
      check("stall_hold", 64'({pix_valid, pix_data, pix_x, pix_y, pix_last}),
            64'({1'b1, prev_pix}));
    prev_stall = pix_valid && !pix_ready && rst_n;
    prev_pix   = {pix_data, pix_x, pix_y, pix_last};

    if (!rst_n) begin
      hist1 = '0;
      hist2 = '0;
    end
    if (frame_start) begin
      q1.delete();
      n1_word = 0;
      c1_fs++;
    end
    if (hist1[L1-1]) begin
      rd_data = {8'(4*n1_word+3), 8'(4*n1_word+2), 8'(4*n1_word+1), 8'(4*n1_word)};
      for (int l = 0; l < P1; l++) begin
        int k;
        k = n1_word * P1 + l;
        if (k < W1 * H1) begin
          e.d = 8'(k); e.x = k % W1; e.y = k / W1; e.last = (k == W1 * H1 - 1);
          q1.push_back(e);
        end
      end
      n1_word++;
    end else begin
      rd_data = BAD;
    end
    hist1 = {hist1[6:0], rd_valid};
    if (rd_valid) begin
      c1_rd++;
      check("rd_addr", 64'(rd_addr), 64'(32'h6C));
    end
    if (pix_valid && pix_ready) begin
      c1_pix++;
      if (pix_last) c1_last++;
      if (q1.size() == 0) begin
        bound_expired("pix1_unexpected");
      end else begin
        e = q1.pop_front();
        check("pix1 {data,x,y,last}", 64'({pix_data, pix_x, pix_y, pix_last}),
              64'({e.d, 5'(e.x), 5'(e.y), e.last}));
      end
    end
    if (frame_done) c1_done++;

    if (b_frame_start) begin
      q2.delete();
      n2_word = 0;
    end
    if (hist2[L2-1]) begin
      b_rd_data = {8'hEE, 8'(3*n2_word+2), 8'(3*n2_word+1), 8'(3*n2_word)};
      for (int l = 0; l < P2; l++) begin
        int k;
        k = n2_word * P2 + l;
        if (k < W2 * H2) begin
          e.d = 8'(k); e.x = k % W2; e.y = k / W2; e.last = (k == W2 * H2 - 1);
          q2.push_back(e);
        end
      end
      n2_word++;
    end else begin
      b_rd_data = BAD;
    end
    hist2 = {hist2[6:0], b_rd_valid};
    if (b_rd_valid) c2_rd++;
    if (b_pix_valid && b_ready) begin
      c2_pix++;
      if (b_pix_last) c2_last++;
      if (q2.size() == 0) begin
        bound_expired("pix2_unexpected");
      end else begin
        e = q2.pop_front();
        check("pix2 {data,x,y,last}", 64'({b_pix_data, b_pix_x, b_pix_y, b_pix_last}),
              64'({e.d, 2'(e.x), 2'(e.y), e.last}));
      end
    end
    if (b_frame_done) c2_done++;
  endtask

  task automatic pulse_start1();
    start = 1'b1;
    tick();
    check("frame_start_busy", 64'({frame_start, busy}), 64'(2'b11));
    start = 1'b0;
  endtask

  task automatic wait_done1(input int base);
    int k = 0;
    while (c1_done == base && k < 20000) begin
      tick();
      k++;
    end
    if (c1_done == base) bound_expired("frame_done_wait");
  endtask

  initial begin
    int b_pix, b_rd, b_done, b_last, b_fs, k;
    start = 1'b0; abort = 1'b0; pix_ready = 1'b1; rd_data = BAD; rx_occ = '0;
    b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b1; b_rd_data = BAD; b_occ = 11'd8;

    runs[0] = '{rnd: 1'b0, occ: 8, exp_pix: 1024, exp_reads: 256, exp_done: 1, exp_last: 1};
    runs[1] = '{rnd: 1'b1, occ: 8, exp_pix: 1024, exp_reads: 256, exp_done: 1, exp_last: 1};
    runs[2] = '{rnd: 1'b0, occ: 1, exp_pix: 1024, exp_reads: 256, exp_done: 1, exp_last: 1};
    runs[3] = '{rnd: 1'b1, occ: 3, exp_pix: 1024, exp_reads: 256, exp_done: 1, exp_last: 1};

    repeat (3) tick();
    check("reset_outputs", 64'({rd_addr, rd_valid, pix_valid, pix_data, pix_x, pix_y, pix_last,
                                frame_start, frame_done, busy, err_timeout}), 64'(0));
    check("reset_outputs2", 64'({b_rd_valid, b_pix_valid, b_busy, b_err}), 64'(0));
    rst_n = 1'b1;
    repeat (2) tick();

    // Full frames under the table's ready/occupancy patterns.
    for (int i = 0; i < 4; i++) begin
      ready_rnd = runs[i].rnd;
      rx_occ = 11'(runs[i].occ);
      b_pix = c1_pix; b_rd = c1_rd; b_done = c1_done; b_last = c1_last;
      pulse_start1();
      wait_done1(b_done);
      repeat (3) tick();
      $display("run %0d: rnd=%0d occ=%0d pixels=%0d reads=%0d done=%0d", i, runs[i].rnd,
               runs[i].occ, c1_pix - b_pix, c1_rd - b_rd, c1_done - b_done);
      check("run_pixels", 64'(c1_pix - b_pix), 64'(runs[i].exp_pix));
      check("run_reads", 64'(c1_rd - b_rd), 64'(runs[i].exp_reads));
      check("run_done", 64'(c1_done - b_done), 64'(runs[i].exp_done));
      check("run_last", 64'(c1_last - b_last), 64'(runs[i].exp_last));
      check("run_idle", 64'({busy, err_timeout}), 64'(0));
    end
    ready_rnd = 1'b0;

    // Occupancy never arrives: timeout after TO1 cycles in WAIT_OCC.
    rx_occ = '0;
    b_rd = c1_rd;
    start = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
      if (k == 1) start = 1'b0;
    end while (!err_timeout && k < 300);
    $display("timeout: err_timeout after %0d cycles", k);
    check("timeout_cycles", 64'(k), 64'(TO1 + 1));
    check("timeout_state", 64'({busy, pix_valid, err_timeout}), 64'(3'b101));
    check("timeout_no_reads", 64'(c1_rd - b_rd), 64'(0));
    repeat (5) tick();
    check("error_sticky", 64'({busy, err_timeout}), 64'(2'b11));
    start = 1'b1;
    tick();
    check("error_exit", 64'({busy, err_timeout}), 64'(2'b01));
    start = 1'b0;
    tick();
    rx_occ = 11'd8;
    b_done = c1_done;
    pulse_start1();
    check("err_cleared_on_start", 64'(err_timeout), 64'(0));
    wait_done1(b_done);
    tick();

    // Abort while the read for pixel 500 is in flight.
    b_pix = c1_pix; b_done = c1_done;
    pulse_start1();
    k = 0;
    while (!((c1_pix - b_pix >= 500) && rd_valid) && k < 10000) begin
      tick();
      k++;
    end
    if (k >= 10000) bound_expired("abort_reach_500");
    tick();
    check("abort_pixel_count", 64'(c1_pix - b_pix), 64'(500));
    abort = 1'b1;
    tick();
    $display("abort: busy=%0d pix_valid=%0d rd_valid=%0d", busy, pix_valid, rd_valid);
    check("abort_idle", 64'({busy, pix_valid, rd_valid}), 64'(0));
    abort = 1'b0;
    repeat (20) tick();
    check("abort_no_done", 64'(c1_done - b_done), 64'(0));
    b_pix = c1_pix;
    pulse_start1();
    wait_done1(b_done);
    tick();
    check("after_abort_pixels", 64'(c1_pix - b_pix), 64'(1024));

    // Abort and start in the same cycle.
    b_fs = c1_fs;
    start = 1'b1;
    abort = 1'b1;
    tick();
    check("abort_beats_start", 64'({busy, frame_start}), 64'(0));
    start = 1'b0;
    abort = 1'b0;
    tick();
    check("abort_beats_start_fs", 64'(c1_fs - b_fs), 64'(0));

    // Start held high runs exactly one frame.
    b_fs = c1_fs; b_done = c1_done;
    start = 1'b1;
    tick();
    wait_done1(b_done);
    repeat (300) tick();
    $display("held start: frames=%0d busy=%0d", c1_fs - b_fs, busy);
    check("held_start_frames", 64'(c1_fs - b_fs), 64'(1));
    check("held_start_idle", 64'(busy), 64'(0));
    start = 1'b0;
    tick();

    // Reset in the middle of a frame.
    b_pix = c1_pix; b_done = c1_done;
    pulse_start1();
    k = 0;
    while (c1_pix - b_pix < 37 && k < 2000) begin
      tick();
      k++;
    end
    if (k >= 2000) bound_expired("midreset_reach");
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", 64'({rd_addr, rd_valid, pix_valid, pix_data, pix_x, pix_y, pix_last,
                                   frame_start, frame_done, busy, err_timeout}), 64'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("midreset_no_pulses", 64'({frame_done, frame_start, busy}), 64'(0));
    check("midreset_no_done", 64'(c1_done - b_done), 64'(0));
    b_pix = c1_pix;
    pulse_start1();
    wait_done1(b_done);
    tick();
    check("after_reset_pixels", 64'(c1_pix - b_pix), 64'(1024));

    // Three lanes per word, 4x4 frame, latency 4: last word keeps only lane 0.
    b_start = 1'b1;
    tick();
    check("dut2_frame_start", 64'({b_frame_start, b_busy}), 64'(2'b11));
    b_start = 1'b0;
    k = 0;
    while (c2_done == 0 && k < 2000) begin
      tick();
      k++;
    end
    if (c2_done == 0) bound_expired("dut2_done_wait");
    repeat (3) tick();
    $display("dut2: reads=%0d pixels=%0d last=%0d done=%0d", c2_rd, c2_pix, c2_last, c2_done);
    check("dut2_reads", 64'(c2_rd), 64'(6));
    check("dut2_pixels", 64'(c2_pix), 64'(16));
    check("dut2_last", 64'(c2_last), 64'(1));
    check("dut2_done", 64'(c2_done), 64'(1));
    check("dut2_idle", 64'(b_busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
